uart_rx_fifo: RTL and testbench

- 8N1 UART receiver with a small receive FIFO; the user-project end of the serial link driven by the testbench UART transmitter on mprj_io[5].
- Deserialises bytes from `rx`, buffers them, and presents them to firmware-facing logic through a valid/ready pop interface.
- Reports framing errors and FIFO overrun.

---
 rtl/uart_rx_fifo.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small show-ahead receive FIFO.
// The serial input is synchronised by two flops. A valid/ready interface pops
// bytes from the FIFO. The block flags framing errors and sticky FIFO overrun.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames. This adds
// a PARITY state and a parity_err output.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 347,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     rx,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     frame_err,
    output logic                     overrun,
    input  logic                     clear_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                     parity_err
`endif
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              sync1_q, rxs_q;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              push_req, parity_bad;

    logic [7:0]        mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]     count_q, count_d;
    logic              pop, full, push_ok;

`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              parity_err_q, parity_err_d;
`endif

    // Two-flop synchroniser; idle-high reset keeps the line looking quiet.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    // Receiver state, bit timing and error-pulse registers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= StWaitIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Even parity: the parity bit must equal the XOR of the data bits.
`ifdef UART_RX_PARITY_EN
    assign parity_bad = (^shift_q) != par_q;
`else
    assign parity_bad = 1'b0;
`endif

    // Next-state logic: mid-bit sampling, and the push/error decision at the stop bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            StWaitIdle: begin
                if (rxs_q) state_d = StIdle;
            end
            StIdle: begin
                if (!rxs_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    state_d = StStop;
`ifdef UART_RX_PARITY_EN
                    par_d   = rxs_q;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == FullCnt) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = parity_bad;
`endif
                    if (rxs_q) begin
                        push_req = !parity_bad;
                        state_d  = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StWaitIdle;
        endcase
    end

    // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        pop       = rx_valid && rx_ready;
        full      = count_q == (PtrW + 1)'(DEPTH);
        push_ok   = push_req && (!full || pop);
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        if (push_req && !push_ok) begin
            overrun_d = 1'b1;
        end else if (clear_err) begin
            overrun_d = 1'b0;
        end
    end

    // FIFO pointers, occupancy and sticky overrun flag.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            overrun_q <= overrun_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents are only observable through count-qualified reads.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx_valid   = count_q != '0;
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign busy       = state_q != StIdle;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. Each frame is judged against a queue
// of expected bytes plus an expected overrun flag.
module tb_uart_rx_fifo;

    localparam int unsigned CPB   = 8;
    localparam int unsigned DEPTH = 4;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [2:0] fifo_count;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       clear_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] exp_q[$];
    logic       exp_ov = 1'b0;
    logic [7:0] stop_pop_data;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clear_err  (clear_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clock = ~clock;

    // Count cycles each error pulse is high.
    always @(posedge clock) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if (parity_err && frame_err) both_cnt <= both_cnt + 1;
`endif
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Sends one frame, starting at a negedge. pop_at_stop pulses rx_ready for the
    // single cycle in which the stop bit is sampled (2 sync + half-bit into stop).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                              input logic pop_at_stop, input logic end_level);
        logic [10:0] seq;
        int          nb;
`ifdef UART_RX_PARITY_EN
        seq = {stop_bit, par_bit, d, 1'b0};
        nb  = 11;
`else
        seq = {par_bit, stop_bit, d, 1'b0};
        nb  = 10;
`endif
        for (int i = 0; i < nb; i++) begin
            rx = seq[i];
            if (pop_at_stop && i == nb - 1) begin
                wait_neg(2 + CPB / 2);
                stop_pop_data = rx_data;
                rx_ready = 1'b1;
                wait_neg(1);
                rx_ready = 1'b0;
                wait_neg(CPB - 3 - CPB / 2);
            end else begin
                wait_neg(CPB);
            end
        end
        rx = end_level;
        wait_neg(2);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, 1'b1, ^d, 1'b0, 1'b1);
    endtask

    // Model of the FIFO: push if room, else the byte is lost and overrun sticks.
    task automatic model_push(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ov = 1'b1;
    endtask

    // Samples the head then pops it with a one-cycle rx_ready pulse.
    task automatic pop_one(output logic [7:0] d, output logic v);
        d = rx_data;
        v = rx_valid;
        rx_ready = 1'b1;
        wait_neg(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset rx_data: got %h want 00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset rx_valid: got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL reset fifo_count: got %0d want 0", fifo_count); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL reset busy: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset frame_err: got %b want 0", frame_err); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset overrun: got %b want 0", overrun); else pass_cnt++;
`ifdef UART_RX_PARITY_EN
        total_cnt++; if (parity_err !== 1'b0) $display("FAIL reset parity_err: got %b want 0", parity_err); else pass_cnt++;
`endif
        wait_neg(2);
        resetb = 1'b1;
        wait_neg(4);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset idle busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_single;
        logic [7:0] d;
        logic       v;
        send_good(8'h3D);
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL single valid: got %b want 1", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h3D) $display("FAIL single data: got %h want 3d", rx_data); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd1) $display("FAIL single count: got %0d want 1", fifo_count); else pass_cnt++;
        pop_one(d, v);
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL single popped valid: got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL single popped data: got %h want 00", rx_data); else pass_cnt++;
    endtask

    task automatic test_glitch;
        int fe0;
        fe0 = fe_cnt;
        rx = 1'b0;
        wait_neg(2);
        rx = 1'b1;
        wait_neg(2);
        total_cnt++; if (busy !== 1'b1) $display("FAIL glitch busy in start: got %b want 1", busy); else pass_cnt++;
        wait_neg(CPB);
        total_cnt++; if (busy !== 1'b0) $display("FAIL glitch busy after: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL glitch count: got %0d want 0", fifo_count); else pass_cnt++;
        total_cnt++; if (fe_cnt !== fe0) $display("FAIL glitch frame_err: got %0d want %0d", fe_cnt, fe0); else pass_cnt++;
    endtask

    task automatic test_frame_err;
        int         fe0;
        logic [7:0] d;
        logic       v;
        fe0 = fe_cnt;
        send_frame(8'h0F, 1'b0, ^8'h0F, 1'b0, 1'b0);
        wait_neg(40);
        total_cnt++; if (fe_cnt !== fe0 + 1) $display("FAIL ferr pulses: got %0d want %0d", fe_cnt, fe0 + 1); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL ferr count: got %0d want 0", fifo_count); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL ferr busy held: got %b want 1", busy); else pass_cnt++;
        rx = 1'b1;
        wait_neg(5);
        total_cnt++; if (busy !== 1'b0) $display("FAIL ferr busy released: got %b want 0", busy); else pass_cnt++;
        send_good(8'h55);
        total_cnt++; if (rx_data !== 8'h55 || fifo_count !== 3'd1)
            $display("FAIL ferr recovery: got %h/%0d want 55/1", rx_data, fifo_count); else pass_cnt++;
        pop_one(d, v);
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        logic       v;
        for (int i = 1; i <= 5; i++) begin
            send_good(8'(i));
            model_push(8'(i));
        end
        total_cnt++; if (fifo_count !== 3'(exp_q.size())) $display("FAIL ovr count: got %0d want %0d", fifo_count, exp_q.size()); else pass_cnt++;
        total_cnt++; if (overrun !== exp_ov) $display("FAIL ovr flag: got %b want %b", overrun, exp_ov); else pass_cnt++;
        while (exp_q.size() > 0) begin
            pop_one(d, v);
            total_cnt++; if (v !== 1'b1 || d !== exp_q[0]) $display("FAIL ovr pop: got %b/%h want 1/%h", v, d, exp_q[0]); else pass_cnt++;
            void'(exp_q.pop_front());
        end
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr sticky: got %b want 1", overrun); else pass_cnt++;
        clear_err = 1'b1;
        wait_neg(1);
        clear_err = 1'b0;
        exp_ov = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr clear: got %b want 0", overrun); else pass_cnt++;
    endtask

    task automatic test_full_pop;
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 4; i++) begin
            send_good(8'hA0 + 8'(i));
            model_push(8'hA0 + 8'(i));
        end
        send_frame(8'hA4, 1'b1, ^8'hA4, 1'b1, 1'b1);
        total_cnt++; if (stop_pop_data !== exp_q[0]) $display("FAIL fullpop popped: got %h want %h", stop_pop_data, exp_q[0]); else pass_cnt++;
        void'(exp_q.pop_front());
        model_push(8'hA4);
        total_cnt++; if (overrun !== exp_ov) $display("FAIL fullpop overrun: got %b want %b", overrun, exp_ov); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'(exp_q.size())) $display("FAIL fullpop count: got %0d want %0d", fifo_count, exp_q.size()); else pass_cnt++;
        while (exp_q.size() > 0) begin
            pop_one(d, v);
            total_cnt++; if (v !== 1'b1 || d !== exp_q[0]) $display("FAIL fullpop drain: got %b/%h want 1/%h", v, d, exp_q[0]); else pass_cnt++;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic       v;
        send_good(8'h11);
        rx = 1'b0;              // start bit of 0x3D
        wait_neg(CPB);
        rx = 1'b1;              // bit0 = 1
        wait_neg(CPB);
        rx = 1'b0;              // bit1 = 0
        wait_neg(CPB / 2);
        resetb = 1'b0;
        wait_neg(2);
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL rstmid count in reset: got %0d want 0", fifo_count); else pass_cnt++;
        resetb = 1'b1;
        wait_neg(100);          // line stays low: any false frame must end without a push
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid busy low line: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL rstmid count: got %0d want 0", fifo_count); else pass_cnt++;
        rx = 1'b1;
        wait_neg(5);
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid busy idle: got %b want 0", busy); else pass_cnt++;
        send_good(8'hC3);
        total_cnt++; if (rx_data !== 8'hC3 || fifo_count !== 3'd1)
            $display("FAIL rstmid next byte: got %h/%0d want c3/1", rx_data, fifo_count); else pass_cnt++;
        pop_one(d, v);
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic [7:0] d;
        logic       v;
        int         npop;
        for (int it = 0; it < 16; it++) begin
            b = 8'($urandom);
            send_good(b);
            model_push(b);
            wait_neg($urandom_range(0, 5));
            total_cnt++; if (fifo_count !== 3'(exp_q.size()) || overrun !== exp_ov)
                $display("FAIL random state %0d: got %0d/%b want %0d/%b", it, fifo_count, overrun, exp_q.size(), exp_ov);
            else pass_cnt++;
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                pop_one(d, v);
                if (exp_q.size() > 0) begin
                    total_cnt++; if (v !== 1'b1 || d !== exp_q[0])
                        $display("FAIL random pop %0d: got %b/%h want 1/%h", it, v, d, exp_q[0]);
                    else pass_cnt++;
                    void'(exp_q.pop_front());
                end else begin
                    total_cnt++; if (v !== 1'b0 || d !== 8'h00)
                        $display("FAIL random empty pop %0d: got %b/%h want 0/00", it, v, d);
                    else pass_cnt++;
                end
            end
        end
        while (exp_q.size() > 0) begin
            pop_one(d, v);
            total_cnt++; if (d !== exp_q[0]) $display("FAIL random drain: got %h want %h", d, exp_q[0]); else pass_cnt++;
            void'(exp_q.pop_front());
        end
        clear_err = 1'b1;
        wait_neg(1);
        clear_err = 1'b0;
        exp_ov = 1'b0;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int pe0, fe0, b0;
        pe0 = pe_cnt;
        fe0 = fe_cnt;
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
        total_cnt++; if (pe_cnt !== pe0 + 1) $display("FAIL parity pulse: got %0d want %0d", pe_cnt, pe0 + 1); else pass_cnt++;
        total_cnt++; if (fifo_count !== 3'd0) $display("FAIL parity no push: got %0d want 0", fifo_count); else pass_cnt++;
        total_cnt++; if (fe_cnt !== fe0) $display("FAIL parity frame_err: got %0d want %0d", fe_cnt, fe0); else pass_cnt++;
        b0 = both_cnt;
        send_frame(8'h03, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_neg(5);
        total_cnt++; if (both_cnt !== b0 + 1) $display("FAIL parity both: got %0d want %0d", both_cnt, b0 + 1); else pass_cnt++;
        send_good(8'h07);
        total_cnt++; if (rx_data !== 8'h07 || fifo_count !== 3'd1)
            $display("FAIL parity good byte: got %h/%0d want 07/1", rx_data, fifo_count); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
